// File: rtl/oserdes_tx_sched_pkg.sv
// Shared types and constants for the OSERDESE2 lane scheduler.
//   state_t         : lane sequencer states
//   W               : parallel word width (D1..D8)
//   TRAIN_A/TRAIN_B : alternating training words used when
//                     OSERDES_TX_SCHED_TRAINING_EN is defined
//   max3()          : elaboration-time helper for sizing counters
package oserdes_tx_pkg;

  localparam int W = 8;

  localparam logic [W-1:0] TRAIN_A = 8'hF0;
  localparam logic [W-1:0] TRAIN_B = 8'h0F;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    SRST   = 3'd1,
    WARMUP = 3'd2,
    IDLE   = 3'd3,
    BURST  = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/oserdes_tx_sched_if.sv
// Word-stream bundle between NUM_REQ requesters and the lane scheduler.
//   req_valid[i]            : requester i presents a word
//   req_data[8i+7:8i]       : word of requester i
//   req_last[i]             : word closes requester i's burst
//   req_ready[i]            : scheduler accepts (valid && ready)
// master = requester side, slave = scheduler side.
interface oserdes_tx_sched_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ*oserdes_tx_pkg::W-1:0]   req_data;
  logic [NUM_REQ-1:0]                     req_last;
  logic [NUM_REQ-1:0]                     req_ready;

  modport master (output req_valid, req_data, req_last, input  req_ready);
  modport slave  (input  req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/oserdes_tx_sched_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   last_i    : index of the previous grant; search starts at last_i+1
//   gnt_oh_o  : one-hot pick (all zero when nothing requests)
//   gnt_idx_o : index of the pick (last_i when nothing requests)
//   any_o     : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  // One extra bit so last_i + NUM_REQ never overflows before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = last_i;
    any_o     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_i} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o     = 1'b1;
        gnt_idx_o = cand[IDX_W-1:0];
      end
    end
    if (any_o) gnt_oh_o = NUM_REQ'(1) << gnt_idx_o;
  end

endmodule

// File: rtl/oserdes_tx_sched.sv
// Scheduler/sequencer for one OSERDESE2 8:1 DDR lane driving an OBUFTDS,
// clocked in the CLKDIV domain.
//   clk, rst       : CLKDIV clock, asynchronous active-low reset
//   pll_locked     : PLL LOCKED (asynchronous, synchronized here)
//   enable         : lane enable
//   req_if (slave) : NUM_REQ word streams with valid/ready/last
//   ser_rst        : OSERDESE2 RST
//   ser_d          : D1..D8 (bit0 = D1, first bit on the wire)
//   ser_t          : T1..T4, 1 = high-Z
//   grant_id       : current or last granted requester
//   lane_up        : lane in IDLE or BURST
//   lock_lost      : sticky, lock dropped while the lane was up
// Optional macro OSERDES_TX_SCHED_TRAINING_EN: fill words alternate F0/0F
// instead of IDLE_WORD.
module oserdes_tx_sched
  import oserdes_tx_pkg::*;
#(
  parameter int           NUM_REQ       = 2,
  parameter int           RST_CYCLES    = 4,
  parameter int           WARMUP_CYCLES = 16,
  parameter int           MAX_BURST     = 8,
  parameter logic [W-1:0] IDLE_WORD     = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pll_locked,
  input  logic                       enable,
  oserdes_tx_sched_if.slave          req_if,
  output logic                       ser_rst,
  output logic [W-1:0]               ser_d,
  output logic                       ser_t,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       lane_up,
  output logic                       lock_lost
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = max3(RST_CYCLES, WARMUP_CYCLES, MAX_BURST);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic               lk_meta_q, lk_q;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [W-1:0]       ser_d_q, ser_d_d;
  logic               ser_rst_q, ser_t_q, lane_up_q, lock_lost_q, lock_lost_d;

  logic               abort, accept, lane_next;
  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [W-1:0]       fill_word;
  logic [W-1:0]       word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign word[g] = req_if.req_data[g*W +: W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i     (req_if.req_valid),
    .last_i    (grant_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // Abort is combinational so ready falls in the same cycle lk/enable drop;
  // that also guarantees no word is accepted on an aborting cycle.
  assign abort            = !lk_q || !enable;
  assign req_if.req_ready = (state_q == BURST && !abort) ? gnt_oh_q : '0;
  assign accept           = |(req_if.req_ready & req_if.req_valid);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    gnt_oh_d    = gnt_oh_q;
    lock_lost_d = lock_lost_q || (!lk_q && lane_up_q);
    case (state_q)
      OFF: begin
        state_d = SRST;
        cnt_d   = '0;
      end
      SRST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WARMUP: begin
        if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (arb_any) begin
          state_d  = BURST;
          grant_d  = arb_idx;
          gnt_oh_d = arb_oh;
          cnt_d    = '0;
        end
      end
      BURST: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (req_if.req_last[grant_q] || cnt_q == CNT_W'(MAX_BURST - 1)) state_d = IDLE;
        end
      end
      default: state_d = OFF;
    endcase
    if (abort) begin
      state_d  = OFF;
      cnt_d    = '0;
      grant_d  = grant_q;
      gnt_oh_d = gnt_oh_q;
    end
  end

  assign lane_next = (state_d == IDLE) || (state_d == BURST);
  assign ser_d_d   = accept ? word[grant_q] : fill_word;

`ifdef OSERDES_TX_SCHED_TRAINING_EN
  // phase_q tracks which training word is on ser_d; it restarts at TRAIN_A
  // on the first lane-up cycle and toggles every lane-up cycle after that.
  logic phase_q, phase_d;

  assign phase_d   = lane_up_q ? ~phase_q : 1'b0;
  assign fill_word = lane_next ? (phase_d ? TRAIN_B : TRAIN_A) : IDLE_WORD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_q <= 1'b0;
    else      phase_q <= phase_d;
  end
`else
  assign fill_word = IDLE_WORD;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lk_meta_q   <= 1'b0;
      lk_q        <= 1'b0;
      state_q     <= OFF;
      cnt_q       <= '0;
      grant_q     <= '0;
      gnt_oh_q    <= NUM_REQ'(1);
      ser_d_q     <= IDLE_WORD;
      ser_rst_q   <= 1'b1;
      ser_t_q     <= 1'b1;
      lane_up_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lk_meta_q   <= pll_locked;
      lk_q        <= lk_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      gnt_oh_q    <= gnt_oh_d;
      ser_d_q     <= ser_d_d;
      // Outputs are registered from the next state so they line up with it.
      ser_rst_q   <= (state_d == OFF) || (state_d == SRST);
      ser_t_q     <= !lane_next;
      lane_up_q   <= lane_next;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign ser_rst   = ser_rst_q;
  assign ser_d     = ser_d_q;
  assign ser_t     = ser_t_q;
  assign grant_id  = grant_q;
  assign lane_up   = lane_up_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_oserdes_tx_sched.sv
// Self-checking bench for oserdes_tx_sched (NUM_REQ=2, default parameters).
// Accepted words are pushed to a scoreboard at the handshake and popped when
// ser_d shows them one cycle later; all other cycles expect the fill word.
module tb_oserdes_tx_sched;

  localparam int NR = 2;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       enable = 1'b0;
  logic       ser_rst;
  logic [7:0] ser_d;
  logic       ser_t;
  logic [0:0] grant_id;
  logic       lane_up;
  logic       lock_lost;

  oserdes_tx_sched_if #(.NUM_REQ(NR)) rif ();

  oserdes_tx_sched #(
    .NUM_REQ(NR), .RST_CYCLES(4), .WARMUP_CYCLES(16), .MAX_BURST(8), .IDLE_WORD(8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .enable     (enable),
    .req_if     (rif),
    .ser_rst    (ser_rst),
    .ser_d      (ser_d),
    .ser_t      (ser_t),
    .grant_id   (grant_id),
    .lane_up    (lane_up),
    .lock_lost  (lock_lost)
  );

  always #5 clk = ~clk;

  beat_t      sq0 [$];
  beat_t      sq1 [$];
  logic [7:0] sb [$];
  int         acc_ids [$];
  int         errors = 0;
  int         checks = 0;
  int         multi_rdy = 0;
  logic [NR-1:0] last_rdy = '0;
  logic [NR-1:0] last_acc = '0;
  logic       tr_ph = 1'b0;
  logic       prev_lane = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // One CLKDIV cycle: drive at negedge, sample handshake, cross posedge,
  // then check ser_d at the following negedge.
  task automatic tick();
    logic [7:0] exp;
    logic [7:0] fill;
    rif.req_valid[0] = (sq0.size() > 0);
    rif.req_data[7:0] = (sq0.size() > 0) ? sq0[0].d : 8'h00;
    rif.req_last[0] = (sq0.size() > 0) ? sq0[0].l : 1'b0;
    rif.req_valid[1] = (sq1.size() > 0);
    rif.req_data[15:8] = (sq1.size() > 0) ? sq1[0].d : 8'h00;
    rif.req_last[1] = (sq1.size() > 0) ? sq1[0].l : 1'b0;
    #1;
    last_rdy = rif.req_ready;
    last_acc = rif.req_valid & rif.req_ready;
    if ($countones(last_rdy) > 1) multi_rdy++;
    if (last_acc[0]) begin
      sb.push_back(sq0[0].d);
      acc_ids.push_back(0);
      sq0.delete(0);
    end
    if (last_acc[1]) begin
      sb.push_back(sq1[0].d);
      acc_ids.push_back(1);
      sq1.delete(0);
    end
    @(posedge clk);
    @(negedge clk);
    if (lane_up && !prev_lane) tr_ph = 1'b0;
    else if (lane_up)          tr_ph = ~tr_ph;
    prev_lane = lane_up;
`ifdef OSERDES_TX_SCHED_TRAINING_EN
    fill = lane_up ? (tr_ph ? 8'h0F : 8'hF0) : 8'h00;
`else
    fill = 8'h00;
`endif
    if (|last_acc) begin
      if (sb.size() > 0) exp = sb.pop_front();
      else               exp = 8'hxx;
    end else begin
      exp = fill;
    end
    chk("ser_d", {24'h0, ser_d}, {24'h0, exp});
  endtask

  // Measures cycles until ser_rst falls and then until ser_t falls.
  task automatic bring_up(input string tag, input int exp_rst, input int exp_warm);
    int t_rst;
    int t_t;
    t_rst = -1;
    t_t   = -1;
    for (int k = 1; k <= 60 && t_t < 0; k++) begin
      tick();
      if (t_rst < 0 && ser_rst == 1'b0) t_rst = k;
      if (t_t < 0 && ser_t == 1'b0)     t_t = k;
    end
    chk({tag, "_srst_cycles"}, t_rst, exp_rst);
    chk({tag, "_warm_cycles"}, t_t - t_rst, exp_warm);
    chk({tag, "_lane_up"}, {31'h0, lane_up}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_rdy;
    int exp_ids [$];
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_last  = '0;
    rst        = 1'b0;
    pll_locked = 1'b1;
    enable     = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_ser_rst",   {31'h0, ser_rst}, 1);
    chk("rst_ser_t",     {31'h0, ser_t}, 1);
    chk("rst_ser_d",     {24'h0, ser_d}, 0);
    chk("rst_ready",     {30'h0, rif.req_ready}, 0);
    chk("rst_grant",     {31'h0, grant_id}, 0);
    chk("rst_lane_up",   {31'h0, lane_up}, 0);
    chk("rst_lock_lost", {31'h0, lock_lost}, 0);

    // 2 synchronizer flops + 1 OFF->SRST cycle, then 4 SRST cycles.
    rst = 1'b1;
    bring_up("boot", 7, 16);

    // Single burst from requester 0.
    sq0.push_back('{8'hA5, 1'b0});
    sq0.push_back('{8'h3C, 1'b1});
    first_rdy = -1;
    for (int k = 1; k <= 20 && sq0.size() > 0; k++) begin
      tick();
      if (first_rdy < 0 && last_rdy[0]) first_rdy = k;
    end
    chk("single_first_ready", first_rdy, 2);
    chk("single_accepts", acc_ids.size(), 2);
    chk("single_grant", {31'h0, grant_id}, 0);
    tick();
    chk("single_back_idle_rdy", {30'h0, last_rdy}, 0);
    chk("single_lane_up", {31'h0, lane_up}, 1);

    // Round robin with two 2-word bursts per requester.
    acc_ids.delete();
    multi_rdy = 0;
    sq0.push_back('{8'h10, 1'b0}); sq0.push_back('{8'h11, 1'b1});
    sq0.push_back('{8'h12, 1'b0}); sq0.push_back('{8'h13, 1'b1});
    sq1.push_back('{8'h20, 1'b0}); sq1.push_back('{8'h21, 1'b1});
    sq1.push_back('{8'h22, 1'b0}); sq1.push_back('{8'h23, 1'b1});
    for (int k = 0; k < 60 && (sq0.size() > 0 || sq1.size() > 0); k++) tick();
    exp_ids = '{1, 1, 0, 0, 1, 1, 0, 0};
    chk("rr_accepts", acc_ids.size(), 8);
    for (int i = 0; i < 8 && i < acc_ids.size(); i++)
      chk($sformatf("rr_order%0d", i), acc_ids[i], exp_ids[i]);
    chk("rr_single_ready", multi_rdy, 0);

    // Burst cap: requester 1 streams without last; requester 0 waits.
    acc_ids.delete();
    for (int k = 0; k < 12; k++) sq1.push_back('{8'h40 + 8'(k), 1'b0});
    sq1.push_back('{8'h4C, 1'b1});
    sq0.push_back('{8'h77, 1'b1});
    for (int k = 0; k < 80 && (sq0.size() > 0 || sq1.size() > 0); k++) tick();
    exp_ids = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    chk("cap_accepts", acc_ids.size(), 14);
    for (int i = 0; i < 14 && i < acc_ids.size(); i++)
      chk($sformatf("cap_order%0d", i), acc_ids[i], exp_ids[i]);
    chk("cap_single_ready", multi_rdy, 0);

    // Enable drop: abort without lock_lost, then sequence restarts from SRST.
    tick();
    enable = 1'b0;
    tick();
    chk("en_lane_down", {31'h0, lane_up}, 0);
    chk("en_ser_t",     {31'h0, ser_t}, 1);
    chk("en_ser_rst",   {31'h0, ser_rst}, 1);
    chk("en_lock_lost", {31'h0, lock_lost}, 0);
    enable = 1'b1;
    bring_up("en", 5, 16);

    // Lock loss after 3 accepts of a burst.
    acc_ids.delete();
    for (int k = 0; k < 10; k++) sq0.push_back('{8'h90 + 8'(k), (k == 9)});
    for (int k = 0; k < 20 && acc_ids.size() < 3; k++) tick();
    chk("ll_pre_accepts", acc_ids.size(), 3);
    pll_locked = 1'b0;
    tick();
    chk("ll_rdy_sync1", {31'h0, last_rdy[0]}, 1);
    tick();
    chk("ll_rdy_sync2", {31'h0, last_rdy[0]}, 1);
    tick();
    chk("ll_rdy_drop",  {30'h0, last_rdy}, 0);
    chk("ll_ser_t",     {31'h0, ser_t}, 1);
    chk("ll_ser_rst",   {31'h0, ser_rst}, 1);
    chk("ll_lane_down", {31'h0, lane_up}, 0);
    chk("ll_lock_lost", {31'h0, lock_lost}, 1);
    repeat (5) tick();
    chk("ll_sticky",    {31'h0, lock_lost}, 1);
    chk("ll_rdy_off",   {30'h0, last_rdy}, 0);
    pll_locked = 1'b1;
    bring_up("relock", 7, 16);
    for (int k = 0; k < 40 && sq0.size() > 0; k++) tick();
    tick();
    chk("ll_total_accepts", acc_ids.size(), 10);
    chk("ll_sticky_end", {31'h0, lock_lost}, 1);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oserdes_tx_sched.md
Name: oserdes_tx_sched

Overview:
- Scheduler and sequencer for one OSERDESE2 (8:1 DDR) lane driving an OBUFTDS.
- Runs in the CLKDIV domain. Sequences SERDES reset and tristate release after PLL lock.
- Shares the lane between NUM_REQ word-stream requesters using round-robin burst arbitration.
- Emits the 8-bit parallel word (D1..D8) and tristate control (T1..T4 tied to one bit) every CLKDIV cycle.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- RST_CYCLES, 4, CLKDIV cycles that ser_rst is held after lock is seen.
- WARMUP_CYCLES, 16, cycles after reset release during which the driver stays tristated.
- MAX_BURST, 8, maximum accepted words per grant.
- IDLE_WORD, 8'h00, word driven when no data is accepted.

Ports:
- clk  in  1  CLKDIV-domain clock.
- rst  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL LOCKED, asynchronous.
- enable  in  1  lane enable.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*8  per-requester word; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  last word of the requester's burst.
- req_ready  out  NUM_REQ  word accepted when valid&&ready.
- ser_rst  out  1  OSERDESE2 RST.
- ser_d  out  8  D1..D8; bit0 = D1, the first serialized bit.
- ser_t  out  1  drives T1..T4; 1 = OBUFTDS high-Z.
- grant_id  out  clog2(NUM_REQ)  current or last granted requester.
- lane_up  out  1  high in IDLE and BURST.
- lock_lost  out  1  sticky flag; set when lock drops while lane_up; cleared only by rst.

Behaviour:
- pll_locked passes through a 2-flop synchronizer; lk denotes the synchronized value.
- Reset values: state OFF, ser_rst=1, ser_t=1, ser_d=IDLE_WORD, req_ready=0, grant_id=0, lane_up=0, lock_lost=0, counters 0.
- State OFF: stays while !lk || !enable. Otherwise moves to SRST with the counter cleared.
- State SRST: ser_rst=1. After RST_CYCLES cycles, moves to WARMUP.
- State WARMUP: ser_rst=0, ser_t=1. After WARMUP_CYCLES cycles, moves to IDLE.
- State IDLE: ser_t=0, ser_d=IDLE_WORD.
  - If any req_valid is high, pick the first valid requester searching upward from grant_id+1, with modulo wrap.
  - Register that requester in grant_id, clear the beat counter, and move to BURST the next cycle.
  - No word is accepted in IDLE.
- State BURST:
  - req_ready[grant_id]=1; all other ready bits are 0.
  - req_ready depends only on registered state, never on req_valid.
  - On accept: ser_d <= the granted word on the next edge (latency 1), and the beat counter increments.
  - On a cycle with no accept: ser_d <= IDLE_WORD and the counter holds.
  - Leaves to IDLE after an accept with req_last=1, or after the accept that makes the count reach MAX_BURST, whichever comes first.
  - A burst cut at MAX_BURST resumes only when that requester wins arbitration again.
- Abort: when !lk || !enable in any state, the next state is OFF and req_ready drops in the same cycle (combinational from lk and enable).
  - ser_rst and ser_t return to 1 on the next edge.
  - The word accepted in that cycle is discarded and does not reach ser_d.
  - If the abort is caused by lk dropping while lane_up, lock_lost is set.
- Outputs ser_d, ser_t, ser_rst, lane_up and grant_id are registered.
- A single-cycle lk glitch still forces the full OFF→SRST→WARMUP sequence.

Optional Feature:
- Macro: OSERDES_TX_SCHED_TRAINING_EN.
- Defined:
  - In IDLE, and on non-accept cycles in BURST, ser_d alternates 8'hF0 and 8'h0F each cycle instead of IDLE_WORD.
  - The phase toggle resets to 8'hF0 on entry to IDLE from WARMUP.
- Undefined: IDLE_WORD is driven; no toggle register exists.

Decomposition:
- Package oserdes_tx_pkg holds:
  - state enum typedef (OFF, SRST, WARMUP, IDLE, BURST);
  - training words TRAIN_A=8'hF0 and TRAIN_B=8'h0F;
  - word width constant W=8.
- One sub-module, rr_arbiter: NUM_REQ requests plus last-grant index in; one-hot pick and index out; purely combinational.

Test Plan:
- Bring-up: rst released with pll_locked=1 and enable=1, then measure:
  - ser_rst=1 for 4 cycles after the synchronizer delay (2 cycles);
  - ser_t=1 for 16 more cycles;
  - then ser_t=0, lane_up=1, ser_d=8'h00.
- Single burst: req0 sends 8'hA5, 8'h3C(last) →
  - one IDLE cycle, then req_ready[0]=1;
  - ser_d=A5 then 3C on the cycles after each accept;
  - back to IDLE with grant_id=0.
- Round robin: both requesters valid continuously, each with 2-word bursts →
  - grant order 1,0,1,0 starting from reset grant_id=0;
  - the non-granted requester's ready is never high.
- Burst cap: req1 streams 12 words with no last →
  - 8 accepts, then IDLE;
  - req0 valid is granted next; req1 resumes after that.
- Lock loss mid-burst: pll_locked→0 after 3 accepts →
  - req_ready drops after the 2-cycle synchronizer;
  - ser_t=1, ser_rst=1 next edge;
  - lock_lost=1 and stays set;
  - relock repeats the full SRST/WARMUP sequence.
- With OSERDES_TX_SCHED_TRAINING_EN defined: idle lane gives ser_d=F0,0F,F0,... starting at F0 on the first IDLE cycle; data words interleave correctly during gaps.
